// File: rtl/mem_port_ctrl_if.sv
// Core-request / memory-port bundle for one mem_port_ctrl instance.
// The master modport is the controller; the slave modport is the core plus memory port it serves.
interface mem_port_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic                      req_wide;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [2*DATA_WIDTH-1:0]   req_wdata;
  logic                      rsp_valid;
  logic [2*DATA_WIDTH-1:0]   rsp_rdata;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_w_addr;
  logic [2*DATA_WIDTH-1:0]   mem_w_data;
  logic [ADDR_WIDTH-1:0]     mem_r_addr;
  logic [DATA_WIDTH-1:0]     mem_r_data;

  modport master (
    input  req_valid, req_write, req_wide, req_addr, req_wdata, mem_r_data,
    output req_ready, rsp_valid, rsp_rdata, mem_we, mem_w_addr, mem_w_data, mem_r_addr
  );

  modport slave (
    output req_valid, req_write, req_wide, req_addr, req_wdata, mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_w_addr, mem_w_data, mem_r_addr
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Per-core memory port initiator: turns 8/16-bit loads and stores into byte reads
// with 1-cycle latency and 16-bit paired-byte writes, using read-modify-write for narrow stores.
module mem_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_ctrl_if.master bus
);

  localparam int WORD_W = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_A = 3'd1,
    LD_B = 3'd2,
    LD_C = 3'd3,
    RM_A = 3'd4,
    RM_B = 3'd5,
    ST   = 3'd6
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic                    write_q;
  logic                    wide_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic                    rsp_valid_q;
  logic [WORD_W-1:0]       rsp_rdata_q;

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    mem_we_c;
  logic [ADDR_WIDTH-1:0]   mem_r_addr_c;

  // Byte address of the upper half; wraps to 0 at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  // Narrow stores rewrite byte A+1 with the value read back during the RMW phase.
  function automatic logic [WORD_W-1:0] store_word(input logic                  wide,
                                                   input logic [WORD_W-1:0]     wdata,
                                                   input logic [DATA_WIDTH-1:0] hi);
    return wide ? wdata : {hi, wdata[DATA_WIDTH-1:0]};
  endfunction

  assign accept   = bus.req_valid && (state == IDLE);
  assign addr_nxt = addr_inc(addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_we_c     = 1'b0;
    mem_r_addr_c = addr_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!bus.req_write) begin
            state_nxt = LD_A;
          end else if (bus.req_wide) begin
            state_nxt = ST;
          end else begin
            state_nxt = RM_A;
          end
        end
      end
      LD_A: state_nxt = LD_B;
      LD_B: begin
        if (wide_q) begin
          mem_r_addr_c = addr_nxt;
          state_nxt    = LD_C;
        end else begin
          state_nxt    = IDLE;
        end
      end
      LD_C: state_nxt = IDLE;
      RM_A: begin
        mem_r_addr_c = addr_nxt;
        state_nxt    = RM_B;
      end
      RM_B: state_nxt = ST;
      ST: begin
        mem_we_c  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_w_addr = addr_q;
  assign bus.mem_w_data = store_word(wide_q, wdata_q, hi_q);
  assign bus.mem_r_addr = mem_r_addr_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

  // Request latch, byte capture from the read port, and completion register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      wide_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
        wide_q  <= bus.req_wide;
      end
      case (state)
        LD_B: begin
          if (wide_q) begin
            lo_q <= bus.mem_r_data;
          end else begin
            rsp_rdata_q <= {{DATA_WIDTH{1'b0}}, bus.mem_r_data};
            rsp_valid_q <= 1'b1;
          end
        end
        LD_C: begin
          rsp_rdata_q <= {bus.mem_r_data, lo_q};
          rsp_valid_q <= 1'b1;
        end
        RM_B: hi_q <= bus.mem_r_data;
        ST: begin
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = write_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: byte-memory model on the port, scoreboard queues for
// responses and writes, per-request latency/read-address/write-count checks.
module tb_mem_port_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  mem_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt   = 0;
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        mem_init_done = 1'b0;
  logic [15:0] exp_rsp_q [$];
  logic [23:0] exp_wr_q  [$];

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:       return 8'h33;
      3:       return 8'd4;
      8:       return 8'd10;
      9:       return 8'd70;
      13:      return 8'd4;
      255:     return 8'hC7;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  function automatic logic [15:0] model_load(input logic wide, input logic [7:0] a);
    logic [7:0] a1;
    a1 = a + 8'd1;
    return wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-wide memory: registered read, paired-byte write
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus_if.mem_we) begin
      mem[bus_if.mem_w_addr]         <= bus_if.mem_w_data[7:0];
      mem[bus_if.mem_w_addr + 8'd1]  <= bus_if.mem_w_data[15:8];
    end
    bus_if.mem_r_data <= mem[bus_if.mem_r_addr];
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_if.mem_we === 1'b1) begin
        logic [23:0] w;
        we_cnt++;
        check("wr_pending", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          w = exp_wr_q.pop_front();
          check("wr_addr", 32'(bus_if.mem_w_addr), 32'(w[23:16]));
          check("wr_data", 32'(bus_if.mem_w_data), 32'(w[15:0]));
        end
      end
      if (bus_if.rsp_valid === 1'b1) begin
        logic [15:0] r;
        check("rsp_pending", 32'(exp_rsp_q.size() != 0), 32'd1);
        if (exp_rsp_q.size() != 0) begin
          r = exp_rsp_q.pop_front();
          check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(r));
        end
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic wide,
                        input logic [7:0] a, input logic [15:0] wd, input logic [15:0] exp_rd);
    int          lat;
    int          exp_lat;
    int          we0;
    logic [7:0]  a1;
    logic [7:0]  ra0;
    logic [7:0]  ra1;
    logic [15:0] wexp;
    a1      = a + 8'd1;
    exp_lat = wr ? (wide ? 1 : 3) : (wide ? 3 : 2);
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus_if.req_ready), 32'd1);
    exp_rsp_q.push_back(exp_rd);
    if (wr) begin
      wexp = wide ? wd : {ref_mem[a1], wd[7:0]};
      exp_wr_q.push_back({a, wexp});
      ref_mem[a]  = wexp[7:0];
      ref_mem[a1] = wexp[15:8];
    end
    we0              = we_cnt;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_wide  = wide;
    bus_if.req_addr  = a;
    bus_if.req_wdata = wd;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'($urandom);
    bus_if.req_wide  = 1'($urandom);
    bus_if.req_addr  = 8'($urandom);
    bus_if.req_wdata = 16'($urandom);
    ra0 = bus_if.mem_r_addr;
    ra1 = ra0;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) ra1 = bus_if.mem_r_addr;
      if (bus_if.rsp_valid === 1'b1) break;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    if (!wr) check({tag, ":raddr0"}, 32'(ra0), 32'(a));
    if (!wr && wide) check({tag, ":raddr1"}, 32'(ra1), 32'(a1));
    if (wr && !wide) check({tag, ":rmw_raddr"}, 32'(ra0), 32'(a1));
    check({tag, ":we_cycles"}, 32'(we_cnt - we0), 32'(wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra;
    logic        rw;
    logic        rwide;
    logic [15:0] rwd;
    int          we_before;

    rst_n            = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_wide  = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst:req_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst:rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst:rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    check("rst:mem_we",    32'(bus_if.mem_we),    32'd0);
    mem_init_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    do_req("wide_ld_8",   1'b0, 1'b1, 8'd8,   16'h0000, 16'h460A);
    do_req("narrow_ld_3", 1'b0, 1'b0, 8'd3,   16'h0000, 16'h0004);
    do_req("wide_st_20",  1'b1, 1'b1, 8'd20,  16'hBEEF, 16'h0000);
    do_req("wide_ld_20",  1'b0, 1'b1, 8'd20,  16'h0000, 16'hBEEF);
    do_req("narrow_st_12",1'b1, 1'b0, 8'd12,  16'h00AA, 16'h0000);
    do_req("narrow_ld_12",1'b0, 1'b0, 8'd12,  16'h0000, 16'h00AA);
    do_req("narrow_ld_13",1'b0, 1'b0, 8'd13,  16'h0000, 16'h0004);
    check("mem12_after_rmw", 32'(mem[12]), 32'h0000_00AA);
    check("mem13_after_rmw", 32'(mem[13]), 32'd4);
    do_req("wrap_ld_255", 1'b0, 1'b1, 8'd255, 16'h0000, 16'h33C7);
    do_req("wrap_st_255", 1'b1, 1'b0, 8'd255, 16'h1234, 16'h0000);
    do_req("wrap_ld2_255",1'b0, 1'b1, 8'd255, 16'h0000, 16'h3334);
    check("mem0_after_wrap", 32'(mem[0]), 32'h0000_0033);

    // Abort a narrow store in RM_B: no write and no response may follow
    @(negedge clk);
    we_before        = we_cnt;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_wide  = 1'b0;
    bus_if.req_addr  = 8'd40;
    bus_if.req_wdata = 16'h0055;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort:mem_we",    32'(bus_if.mem_we),    32'd0);
    check("abort:rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("abort:rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    check("abort:req_ready", 32'(bus_if.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort:no_write", 32'(we_cnt - we_before), 32'd0);
    check("abort:mem40",    32'(mem[40]), 32'(ref_mem[40]));
    check("abort:ready",    32'(bus_if.req_ready), 32'd1);

    do_req("post_rst_ld", 1'b0, 1'b1, 8'd40, 16'h0000, model_load(1'b1, 8'd40));
    do_req("b2b_ld",      1'b0, 1'b0, 8'd9,  16'h0000, model_load(1'b0, 8'd9));

    for (int k = 0; k < 16; k++) begin
      ra    = (k % 5 == 4) ? 8'd255 : 8'(64 + $urandom_range(0, 15));
      rw    = 1'($urandom);
      rwide = 1'($urandom);
      rwd   = 16'($urandom);
      do_req("rand", rw, rwide, ra, rwd, rw ? 16'h0000 : model_load(rwide, ra));
    end

    repeat (3) @(negedge clk);
    check("drain:rsp_q", 32'(exp_rsp_q.size()), 32'd0);
    check("drain:wr_q",  32'(exp_wr_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
